// File: rtl/display_scan_if.sv
// display_scan_if: bundles the time/date fields and selectors driven into the
// scan driver, together with the segment/digit lines it drives out.
//   master : field source (drives fields, Blink, Display; observes Seg, Dig)
//   slave  : display_scan (consumes fields, drives Seg, Dig)
// Signals:
//   Sec_Time[5:0], Min_Time[5:0], Hr_Time[4:0]      binary time fields
//   Day_Date[5:0], Mon_Date[3:0], Year_Date[6:0]    binary date fields
//   Blink[1:0]   pair being edited (00 none, 01 right, 10 middle, 11 left)
//   Display      page select (0 Hr/Min/Sec, 1 Year/Mon/Day)
//   Seg[7:0]     active-low segments, Seg[7] = dp, Seg[6:0] = g..a
//   Dig[5:0]     active-low digit enables, Dig[0] rightmost
interface display_scan_if;
  logic [5:0] Sec_Time;
  logic [5:0] Min_Time;
  logic [4:0] Hr_Time;
  logic [5:0] Day_Date;
  logic [3:0] Mon_Date;
  logic [6:0] Year_Date;
  logic [1:0] Blink;
  logic       Display;
  logic [7:0] Seg;
  logic [5:0] Dig;

  modport master (
    output Sec_Time, Min_Time, Hr_Time, Day_Date, Mon_Date, Year_Date, Blink, Display,
    input  Seg, Dig
  );

  modport slave (
    input  Sec_Time, Min_Time, Hr_Time, Day_Date, Mon_Date, Year_Date, Blink, Display,
    output Seg, Dig
  );
endinterface

// File: rtl/display_scan.sv
// display_scan: six-digit multiplexed common-anode seven-segment driver.
// Converts the selected page (Hr/Min/Sec or Year/Mon/Day) to two-digit decimal
// per field and scans digits 0..5, one slot of SCAN_DIV clocks each. The first
// clock of every slot is blank to suppress ghosting. The field under edit is
// blanked on alternate BLINK_DIV-clock phases.
// Ports:
//   clk_32_768K  system clock, rising edge
//   Rst_n        synchronous active-low reset
//   bus          display_scan_if.slave (fields/selectors in, Seg/Dig out)
module display_scan #(
  parameter int unsigned SCAN_DIV  = 32,
  parameter int unsigned BLINK_DIV = 16384
) (
  input logic             clk_32_768K,
  input logic             Rst_n,
  display_scan_if.slave   bus
);

  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  // Segment pattern for one decimal digit (active low, dp off).
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Tens or units pattern of a field; out-of-range values show a dash.
  // Tens come from a repeated compare/subtract of ten (at most nine steps).
  function automatic logic [7:0] field_seg(input logic [6:0] v, input logic tens);
    logic [6:0] r;
    logic [3:0] t;
    logic [7:0] s;
    r = v;
    t = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (r >= 7'd10) begin
        r = r - 7'd10;
        t = t + 4'd1;
      end
    end
    if (v >= 7'd100) s = 8'hBF;
    else             s = seg7(tens ? t : r[3:0]);
    return s;
  endfunction

  // Scan state
  logic [ScanW-1:0]  slot_cnt_q, slot_cnt_d;
  logic [2:0]        idx_q, idx_d;
  // Blink state
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              vis_q, vis_d;
  logic [1:0]        pblink_q;
  // Frame snapshot
  logic [5:0]        snap_sec_q, snap_min_q, snap_day_q;
  logic [4:0]        snap_hr_q;
  logic [3:0]        snap_mon_q;
  logic [6:0]        snap_year_q;
  logic              snap_disp_q;
  logic              snap_load;
  // Registered outputs
  logic [7:0]        seg_q, seg_d;
  logic [5:0]        dig_q, dig_d;

  logic [6:0]        field_v;
  logic [1:0]        pair_sel;
  logic              pair_blank;
  logic [7:0]        digit_seg;

  always_comb begin
    // idx_q[2:1]: 0 right pair, 1 middle pair, 2 left pair
    field_v = 7'd0;
    unique case (idx_q[2:1])
      2'd2:    field_v = snap_disp_q ? snap_year_q : {2'b00, snap_hr_q};
      2'd1:    field_v = snap_disp_q ? {3'b000, snap_mon_q} : {1'b0, snap_min_q};
      default: field_v = snap_disp_q ? {1'b0, snap_day_q} : {1'b0, snap_sec_q};
    endcase

    // Blink code of the pair containing the current digit: 01/10/11
    pair_sel   = idx_q[2:1] + 2'd1;
    pair_blank = (pblink_q != 2'b00) && !vis_q && (pair_sel == pblink_q);

    digit_seg = field_seg(field_v, idx_q[0]);
    if (idx_q == 3'd2 || idx_q == 3'd4) digit_seg[7] = 1'b0;

    if (slot_cnt_q == '0) begin
      seg_d = 8'hFF;
      dig_d = 6'h3F;
    end else begin
      seg_d = pair_blank ? 8'hFF : digit_seg;
      dig_d = ~(6'b000001 << idx_q);
    end

    snap_load = (slot_cnt_q == '0) && (idx_q == 3'd0);

    slot_cnt_d = slot_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_cnt_q == ScanLast) begin
      slot_cnt_d = '0;
      idx_d      = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end

    // A change of edit selection restarts the phase with the field visible.
    blink_cnt_d = blink_cnt_q + 1'b1;
    vis_d       = vis_q;
    if (bus.Blink != pblink_q) begin
      blink_cnt_d = '0;
      vis_d       = 1'b1;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      vis_d       = ~vis_q;
    end
  end

  always_ff @(posedge clk_32_768K) begin
    if (!Rst_n) begin
      slot_cnt_q  <= '0;
      idx_q       <= 3'd0;
      blink_cnt_q <= '0;
      vis_q       <= 1'b1;
      pblink_q    <= 2'b00;
      snap_sec_q  <= '0;
      snap_min_q  <= '0;
      snap_hr_q   <= '0;
      snap_day_q  <= '0;
      snap_mon_q  <= '0;
      snap_year_q <= '0;
      snap_disp_q <= 1'b0;
      seg_q       <= 8'hFF;
      dig_q       <= 6'h3F;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      vis_q       <= vis_d;
      pblink_q    <= bus.Blink;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
      // Loaded during the blank cycle of slot 0, so a frame never tears.
      if (snap_load) begin
        snap_sec_q  <= bus.Sec_Time;
        snap_min_q  <= bus.Min_Time;
        snap_hr_q   <= bus.Hr_Time;
        snap_day_q  <= bus.Day_Date;
        snap_mon_q  <= bus.Mon_Date;
        snap_year_q <= bus.Year_Date;
        snap_disp_q <= bus.Display;
      end
    end
  end

  assign bus.Seg = seg_q;
  assign bus.Dig = dig_q;

endmodule
